// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator for decode: extracts/extends the immediate,
// computes pc+imm, and buffers results in a small valid/ready FIFO.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam logic [2:0] SEL_I     = 3'd0;
    localparam logic [2:0] SEL_S     = 3'd1;
    localparam logic [2:0] SEL_B     = 3'd2;
    localparam logic [2:0] SEL_U     = 3'd3;
    localparam logic [2:0] SEL_J     = 3'd4;
    localparam logic [2:0] SEL_Z     = 3'd5;
    localparam logic [2:0] SEL_SHAMT = 3'd6;
    localparam logic [2:0] SEL_AUTO  = 3'd7;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
        if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
            $error("imm_gen_pipe: DEPTH must be 1 or 2");
        end
    endgenerate

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [2:0]      fmt_sel;
    logic            shamt_narrow;
    logic            illegal_next;
    logic [XLEN-1:0] imm_next;
    logic [XLEN-1:0] target_next;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // AUTO resolves to a concrete format; unknown opcodes keep SEL_AUTO, which yields imm=0.
    always_comb begin
        fmt_sel      = in_imm_sel;
        shamt_narrow = (XLEN == 32);
        illegal_next = 1'b0;
        if (in_imm_sel == SEL_AUTO) begin
            case (opcode)
                OP_IMM:            fmt_sel = is_shift ? SEL_SHAMT : SEL_I;
                OP_LOAD, OP_JALR:  fmt_sel = SEL_I;
                OP_STORE:          fmt_sel = SEL_S;
                OP_BRANCH:         fmt_sel = SEL_B;
                OP_LUI, OP_AUIPC:  fmt_sel = SEL_U;
                OP_JAL:            fmt_sel = SEL_J;
                OP_SYSTEM:         fmt_sel = SEL_Z;
                OP_IMM_32: begin
                    if (XLEN == 64) begin
                        fmt_sel      = is_shift ? SEL_SHAMT : SEL_I;
                        shamt_narrow = 1'b1;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
                default:           illegal_next = 1'b1;
            endcase
        end
    end

    always_comb begin
        imm_next = '0;
        case (fmt_sel)
            SEL_I:     imm_next = XLEN'($signed(in_instr[31:20]));
            SEL_S:     imm_next = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            SEL_B:     imm_next = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                                 in_instr[11:8], 1'b0}));
            SEL_U:     imm_next = XLEN'($signed({in_instr[31:12], 12'b0}));
            SEL_J:     imm_next = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                                 in_instr[30:21], 1'b0}));
            SEL_Z:     imm_next = XLEN'(in_instr[19:15]);
            SEL_SHAMT: imm_next = shamt_narrow ? XLEN'(in_instr[24:20]) : XLEN'(in_instr[25:20]);
            default:   imm_next = '0;
        endcase
    end

    assign target_next = in_pc + imm_next;

    logic [XLEN-1:0]  imm_mem_reg [DEPTH];
    logic [XLEN-1:0]  tgt_mem_reg [DEPTH];
    logic [DEPTH-1:0] ill_mem_reg;
    logic [1:0]       count_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic             push;
    logic             pop;

    function automatic logic ptr_inc(input logic p);
        return (DEPTH == 2) ? ~p : 1'b0;
    endfunction

    assign in_ready  = (count_reg < 2'(DEPTH)) && !flush;
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            ill_mem_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem_reg[i] <= '0;
                tgt_mem_reg[i] <= '0;
            end
        end else if (flush) begin
            // Collapse to empty without moving the read side; data is masked while empty.
            count_reg  <= '0;
            wr_ptr_reg <= rd_ptr_reg;
        end else begin
            if (push) begin
                imm_mem_reg[wr_ptr_reg] <= imm_next;
                tgt_mem_reg[wr_ptr_reg] <= target_next;
                ill_mem_reg[wr_ptr_reg] <= illegal_next;
                wr_ptr_reg              <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_imm     = out_valid ? imm_mem_reg[rd_ptr_reg] : '0;
    assign out_target  = out_valid ? tgt_mem_reg[rd_ptr_reg] : '0;
    assign out_illegal = out_valid && ill_mem_reg[rd_ptr_reg];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: scoreboard on the XLEN=32 instance plus a few XLEN=64 checks.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_target;
    logic [2:0]  in_imm_sel;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_illegal;
    logic [31:0] w_in_instr;
    logic [63:0] w_in_pc, w_out_imm, w_out_target;
    logic [2:0]  w_in_imm_sel;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_imm_sel(in_imm_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_target(out_target),
        .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_instr(w_in_instr), .in_pc(w_in_pc), .in_imm_sel(w_in_imm_sel),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
        .out_target(w_out_target), .out_illegal(w_out_illegal)
    );

    typedef struct { logic [31:0] imm; logic [31:0] tgt; logic ill; } exp32_t;
    typedef struct { logic [63:0] imm; logic [63:0] tgt; logic ill; } exp64_t;
    exp32_t sb32[$];
    exp64_t sb64[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Every accepted head of the 32-bit instance is checked against the scoreboard.
    always @(negedge clk) begin : mon32
        exp32_t e;
        if (!rst && out_valid && out_ready) begin
            total_cnt++;
            if (sb32.size() == 0) begin
                $display("FAIL head_unexpected got imm=%h tgt=%h ill=%b, scoreboard empty",
                         out_imm, out_target, out_illegal);
            end else begin
                e = sb32.pop_front();
                if (out_imm !== e.imm || out_target !== e.tgt || out_illegal !== e.ill)
                    $display("FAIL head_data got imm=%h tgt=%h ill=%b want imm=%h tgt=%h ill=%b",
                             out_imm, out_target, out_illegal, e.imm, e.tgt, e.ill);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic expect32(input logic [31:0] ei, input logic [31:0] et, input logic eil);
        exp32_t e;
        e.imm = ei; e.tgt = et; e.ill = eil;
        sb32.push_back(e);
    endtask

    // Offers one instruction and waits (bounded) until it is accepted.
    task automatic offer(input logic [2:0] sel, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] ei, input logic [31:0] et, input logic eil,
                         input bit track);
        in_valid = 1'b1; in_imm_sel = sel; in_instr = instr; in_pc = pc;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                if (track) expect32(ei, et, eil);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        $display("FAIL offer_timeout in_ready got 0 want 1 for instr %h", instr);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && sb32.size() != 0; n++) @(negedge clk);
        @(posedge clk); #1;
        total_cnt++;
        if (sb32.size() != 0)
            $display("FAIL %s_drain pending got %0d want 0", name, sb32.size());
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_imm_sel = '0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
        w_in_instr = '0; w_in_pc = '0; w_in_imm_sel = '0;
        #2;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_imm !== 32'h0) $display("FAIL reset_out_imm got %h want 0", out_imm); else pass_cnt++;
        total_cnt++; if (out_target !== 32'h0) $display("FAIL reset_out_target got %h want 0", out_target); else pass_cnt++;
        total_cnt++; if (out_illegal !== 1'b0) $display("FAIL reset_out_illegal got %b want 0", out_illegal); else pass_cnt++;
        total_cnt++; if (w_out_valid !== 1'b0 || w_out_imm !== 64'h0) $display("FAIL reset_w_out got v=%b imm=%h want 0", w_out_valid, w_out_imm); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_formats();
        out_ready = 1'b1;
        offer(3'd0, 32'hFFF00093, 32'h100,      32'hFFFFFFFF, 32'h000000FF, 1'b0, 1'b1);
        offer(3'd7, 32'hFE000EE3, 32'h1000,     32'hFFFFFFFC, 32'h00000FFC, 1'b0, 1'b1);
        offer(3'd7, 32'h00000000, 32'h2000,     32'h0,        32'h2000,     1'b1, 1'b1);
        offer(3'd1, 32'hFE000C23, 32'h40,       32'hFFFFFFF8, 32'h38,       1'b0, 1'b1);
        offer(3'd2, 32'hFE000EE3, 32'h1000,     32'hFFFFFFFC, 32'h00000FFC, 1'b0, 1'b1);
        offer(3'd3, 32'h12345037, 32'h10,       32'h12345000, 32'h12345010, 1'b0, 1'b1);
        offer(3'd4, 32'h0040006F, 32'h0,        32'h4,        32'h4,        1'b0, 1'b1);
        offer(3'd5, 32'hFFFF8073, 32'h100,      32'h1F,       32'h11F,      1'b0, 1'b1);
        offer(3'd6, 32'h03F00013, 32'h0,        32'h1F,       32'h1F,       1'b0, 1'b1);
        offer(3'd7, 32'h40305013, 32'h8,        32'h3,        32'hB,        1'b0, 1'b1);
        offer(3'd0, 32'h40305013, 32'h0,        32'h403,      32'h403,      1'b0, 1'b1);
        offer(3'd7, 32'h800000B7, 32'h80000000, 32'h80000000, 32'h0,        1'b0, 1'b1);
        offer(3'd7, 32'h00028073, 32'h0,        32'h5,        32'h5,        1'b0, 1'b1);
        offer(3'd7, 32'h00402083, 32'h0,        32'h4,        32'h4,        1'b0, 1'b1);
        offer(3'd7, 32'h0230909B, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1);
        offer(3'd7, 32'hFFDFF06F, 32'h20,       32'hFFFFFFFC, 32'h1C,       1'b0, 1'b1);
        drain("formats");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm_sel = 3'd3; in_instr = 32'h12345037; in_pc = 32'h10;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_first got %b want 1", in_ready); else pass_cnt++;
        expect32(32'h12345000, 32'h12345010, 1'b0);
        @(posedge clk); #1;
        in_imm_sel = 3'd4; in_instr = 32'h0040006F; in_pc = 32'h0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_second got %b want 1", in_ready); else pass_cnt++;
        expect32(32'h4, 32'h4, 1'b0);
        @(posedge clk); #1;
        in_imm_sel = 3'd5; in_instr = 32'hFFFF8073; in_pc = 32'h100;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1 || out_imm !== 32'h12345000) $display("FAIL bp_head_stable got v=%b imm=%h want v=1 imm=12345000", out_valid, out_imm); else pass_cnt++;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_no_passthrough got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop got %b want 1", in_ready); else pass_cnt++;
        expect32(32'h1F, 32'h11F, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        drain("back_to_back");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(3'd0, 32'hFFF00093, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        offer(3'd4, 32'h0040006F, 32'h0,   32'h0, 32'h0, 1'b0, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_imm_sel = 3'd3; in_instr = 32'h12345037; in_pc = 32'h0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_empty_ready got %b want 1", in_ready); else pass_cnt++;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_not_captured got %b want 0", out_valid); else pass_cnt++;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        offer(3'd0, 32'hFFF00093, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        offer(3'd1, 32'hFE000C23, 32'h40,  32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL areset_pre_valid got %b want 1", out_valid); else pass_cnt++;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || out_imm !== 32'h0) $display("FAIL areset_immediate got v=%b imm=%h want v=0 imm=0", out_valid, out_imm); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        offer(3'd4, 32'h0040006F, 32'hFFFFFFFC, 32'h4, 32'h0, 1'b0, 1'b1);
        drain("async_reset");
    endtask

    task automatic test_xlen64();
        logic [31:0] v_instr [4] = '{32'h800000B7, 32'h03F09093, 32'h0230909B, 32'h03F00013};
        logic [2:0]  v_sel   [4] = '{3'd7, 3'd7, 3'd7, 3'd6};
        logic [63:0] v_pc    [4] = '{64'h0, 64'h1000, 64'h1000, 64'h0};
        logic [63:0] v_imm   [4] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h3, 64'h3F};
        logic [63:0] v_tgt   [4] = '{64'hFFFFFFFF80000000, 64'h103F, 64'h1003, 64'h3F};
        exp64_t e;
        for (int k = 0; k < 4; k++) begin
            w_in_valid = 1'b1; w_in_sel_set(v_sel[k]); w_in_instr = v_instr[k]; w_in_pc = v_pc[k];
            @(negedge clk);
            total_cnt++; if (w_in_ready !== 1'b1) $display("FAIL x64_in_ready[%0d] got %b want 1", k, w_in_ready); else pass_cnt++;
            e.imm = v_imm[k]; e.tgt = v_tgt[k]; e.ill = 1'b0;
            sb64.push_back(e);
            @(posedge clk); #1 w_in_valid = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (w_out_valid !== 1'b1) begin
                $display("FAIL x64_out_valid[%0d] got %b want 1", k, w_out_valid);
            end else begin
                e = sb64.pop_front();
                if (w_out_imm !== e.imm || w_out_target !== e.tgt || w_out_illegal !== e.ill)
                    $display("FAIL x64_head[%0d] got imm=%h tgt=%h ill=%b want imm=%h tgt=%h ill=%b",
                             k, w_out_imm, w_out_target, w_out_illegal, e.imm, e.tgt, e.ill);
                else
                    pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic w_in_sel_set(input logic [2:0] s);
        w_in_imm_sel = s;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_xlen64();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
